// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: latch/PC enables, flushes and the mult/div occupancy FSM.
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles and flush_count performance counters.
module pipeline_hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] fd_rs,
    input  logic [REG_ADDR_W-1:0] fd_rt,
    input  logic                  fd_uses_rs,
    input  logic                  fd_uses_rt,
    input  logic                  dx_is_load,
    input  logic [REG_ADDR_W-1:0] dx_rd,
    input  logic                  branch_taken,
    input  logic                  md_start,
    input  logic                  mem_stall,
    output logic                  pc_en,
    output logic                  fd_en,
    output logic                  dx_en,
    output logic                  xm_en,
    output logic                  mw_en,
    output logic                  fd_flush,
    output logic                  dx_flush,
    output logic                  xm_bubble,
    output logic                  md_busy,
    output logic                  md_done
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count
`endif
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             lu;

    assign lu = dx_is_load && (dx_rd != '0) &&
                ((fd_uses_rs && (fd_rs == dx_rd)) || (fd_uses_rt && (fd_rt == dx_rd)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // A memory stall freezes the FSM entirely, so no mult/div cycle is consumed.
    always_comb begin
        state_next = state;
        count_next = count;
        if (!mem_stall) begin
            case (state)
                RUN: begin
                    if (md_start) begin
                        state_next = MD_BUSY;
                        count_next = MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (count != '0) begin
                        count_next = count - CNT_W'(1);
                    end else begin
                        state_next = RUN;
                        count_next = '0;
                    end
                end
                default: begin
                    state_next = RUN;
                    count_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        pc_en     = 1'b0;
        fd_en     = 1'b0;
        dx_en     = 1'b0;
        xm_en     = 1'b0;
        mw_en     = 1'b0;
        fd_flush  = 1'b0;
        dx_flush  = 1'b0;
        xm_bubble = 1'b0;
        md_busy   = 1'b0;
        md_done   = 1'b0;
        if (reset) begin
            md_busy = (state == MD_BUSY);
            if (mem_stall) begin
                pc_en = 1'b0;
            end else if ((state == MD_BUSY && count != '0) || (state == RUN && md_start)) begin
                xm_en     = 1'b1;
                xm_bubble = 1'b1;
                mw_en     = 1'b1;
            end else if (state == MD_BUSY) begin
                {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b11111;
                md_done = 1'b1;
            end else if (branch_taken) begin
                {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b11111;
                fd_flush = 1'b1;
                dx_flush = 1'b1;
            end else if (lu) begin
                {dx_en, xm_en, mw_en} = 3'b111;
                dx_flush = 1'b1;
            end else begin
                {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b11111;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // fd_flush is raised only by a taken-branch redirect, so it doubles as the flush event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
            if (fd_flush) flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-counting reference model of the hazard priority rules.
module tb_pipeline_hazard_ctrl;

    localparam int L  = 4;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] fd_rs, fd_rt, dx_rd;
    logic          fd_uses_rs, fd_uses_rt, dx_is_load, branch_taken, md_start, mem_stall;
    logic          pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_bubble, md_busy, md_done;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]   stall_cycles, flush_count;
`endif

    logic [9:0] obs;
    assign obs = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_flush, xm_bubble, md_busy, md_done};

    localparam logic [9:0] P_RUN    = 10'b11111_000_00;
    localparam logic [9:0] P_MDGO   = 10'b00011_001_00;
    localparam logic [9:0] P_MDSTL  = 10'b00011_001_10;
    localparam logic [9:0] P_DONE   = 10'b11111_000_11;
    localparam logic [9:0] P_BRANCH = 10'b11111_110_00;
    localparam logic [9:0] P_LU     = 10'b00111_010_00;
    localparam logic [9:0] P_MEMMD  = 10'b00000_000_10;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: md_elapsed counts executed cycles since the mult/div started.
    bit m_active   = 1'b0;
    int m_elapsed  = 0;
    int m_stalls   = 0;
    int m_flushes  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MD_LATENCY(L), .REG_ADDR_W(AW), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
        .dx_is_load(dx_is_load), .dx_rd(dx_rd), .branch_taken(branch_taken),
        .md_start(md_start), .mem_stall(mem_stall),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_bubble(xm_bubble),
        .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    function automatic logic [9:0] model_out();
        logic lu;
        lu = dx_is_load && (dx_rd != 0) &&
             ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
        if (!reset)                        return 10'b0;
        if (mem_stall)                     return {8'b0, m_active, 1'b0};
        if (m_active && m_elapsed < L)     return P_MDSTL;
        if (m_active)                      return P_DONE;
        if (md_start)                      return P_MDGO;
        if (branch_taken)                  return P_BRANCH;
        if (lu)                            return P_LU;
        return P_RUN;
    endfunction

    task automatic set_idle();
        fd_rs = '0; fd_rt = '0; dx_rd = '0;
        fd_uses_rs = 1'b0; fd_uses_rt = 1'b0; dx_is_load = 1'b0;
        branch_taken = 1'b0; md_start = 1'b0; mem_stall = 1'b0;
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_elapsed = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        set_idle();
    endtask

    task automatic advance();
        logic [9:0] e;
        e = model_out();
        @(posedge clk);
        if (reset) begin
            if (!e[9]) m_stalls++;
            if (e[4])  m_flushes++;
            if (!mem_stall) begin
                if (m_active) begin
                    if (m_elapsed == L) m_active = 1'b0;
                    else m_elapsed++;
                end else if (md_start) begin
                    m_active  = 1'b1;
                    m_elapsed = 1;
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        model_reset();
        #1;
        compared++;
        if (obs !== 10'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got=%b exp=%b", obs, 10'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        compared++;
        if (obs !== P_RUN) begin
            mismatched++;
            $display("[TB] FAIL reset_release got=%b exp=%b", obs, P_RUN);
        end
        advance();
        begin_cycle();
        advance();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compared++;
        if (obs !== 10'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_async got=%b exp=%b", obs, 10'b0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_load_use();
        logic [9:0] exp_tab [3];
        exp_tab = '{P_LU, P_RUN, P_RUN};
        for (int i = 0; i < 3; i++) begin
            begin_cycle();
            if (i == 0) begin
                dx_is_load = 1'b1; dx_rd = 5'd8; fd_rs = 5'd8; fd_uses_rs = 1'b1;
            end else if (i == 2) begin
                dx_is_load = 1'b1; dx_rd = 5'd0; fd_rs = 5'd0; fd_uses_rs = 1'b1;
            end
            #1;
            compared++;
            if (obs !== exp_tab[i]) begin
                mismatched++;
                $display("[TB] FAIL load_use step%0d got=%b exp=%b", i, obs, exp_tab[i]);
            end
            advance();
        end
    endtask

    task automatic test_md_latency();
        logic [9:0] exp_tab [6];
        int done_pulses;
        exp_tab = '{P_MDGO, P_MDSTL, P_MDSTL, P_MDSTL, P_DONE, P_RUN};
        done_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            begin_cycle();
            md_start = (i < 5);
            #1;
            done_pulses += int'(md_done);
            compared++;
            if (obs !== exp_tab[i]) begin
                mismatched++;
                $display("[TB] FAIL md_latency cyc%0d got=%b exp=%b", i, obs, exp_tab[i]);
            end
            advance();
        end
        compared++;
        if (done_pulses !== 1) begin
            mismatched++;
            $display("[TB] FAIL md_done_count got=%0d exp=1", done_pulses);
        end
    endtask

    task automatic test_priority();
        begin_cycle();
        branch_taken = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd3; fd_rt = 5'd3; fd_uses_rt = 1'b1;
        #1;
        compared++;
        if (obs !== P_BRANCH) begin
            mismatched++;
            $display("[TB] FAIL branch_over_lu got=%b exp=%b", obs, P_BRANCH);
        end
        advance();
        begin_cycle();
        branch_taken = 1'b1; md_start = 1'b1;
        #1;
        compared++;
        if (obs !== P_MDGO) begin
            mismatched++;
            $display("[TB] FAIL md_over_branch got=%b exp=%b", obs, P_MDGO);
        end
        advance();
        for (int i = 0; i < L + 1; i++) begin
            begin_cycle();
            branch_taken = (i == 1);
            #1;
            compared++;
            if (obs !== model_out()) begin
                mismatched++;
                $display("[TB] FAIL md_drain cyc%0d got=%b exp=%b", i, obs, model_out());
            end
            advance();
        end
    endtask

    task automatic test_mem_stall_freeze();
        logic [9:0] exp_tab [9];
        exp_tab = '{P_MDGO, P_MDSTL, P_MEMMD, P_MEMMD, P_MEMMD, P_MDSTL, P_MDSTL, P_DONE, P_RUN};
        for (int i = 0; i < 9; i++) begin
            begin_cycle();
            md_start  = (i == 0);
            mem_stall = (i >= 2 && i <= 4);
            #1;
            compared++;
            if (obs !== exp_tab[i]) begin
                mismatched++;
                $display("[TB] FAIL mem_stall_freeze cyc%0d got=%b exp=%b", i, obs, exp_tab[i]);
            end
            advance();
        end
    endtask

    task automatic test_md_abort();
        begin_cycle();
        md_start = 1'b1;
        advance();
        begin_cycle();
        advance();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        compared++;
        if (obs !== 10'b0) begin
            mismatched++;
            $display("[TB] FAIL md_abort_reset got=%b exp=%b", obs, 10'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        advance();
        for (int i = 0; i < L + 2; i++) begin
            begin_cycle();
            #1;
            compared++;
            if (obs !== P_RUN) begin
                mismatched++;
                $display("[TB] FAIL md_abort_after cyc%0d got=%b exp=%b", i, obs, P_RUN);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [9:0] e;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            begin_cycle();
            fd_rs        = AW'($urandom_range(0, 3));
            fd_rt        = AW'($urandom_range(0, 3));
            dx_rd        = AW'($urandom_range(0, 3));
            fd_uses_rs   = 1'($urandom_range(0, 1));
            fd_uses_rt   = 1'($urandom_range(0, 1));
            dx_is_load   = ($urandom_range(0, 99) < 40);
            branch_taken = ($urandom_range(0, 99) < 20);
            md_start     = ($urandom_range(0, 99) < 10);
            mem_stall    = ($urandom_range(0, 99) < 15);
            #1;
            e = model_out();
            compared++;
            if (obs !== e) begin
                mismatched++;
                bad++;
                if (bad <= 10)
                    $display("[TB] FAIL random cyc%0d got=%b exp=%b", i, obs, e);
            end
            advance();
        end
`ifdef HAZARD_PERF_CNT_EN
        #1;
        compared++;
        if (stall_cycles !== 32'(m_stalls) || flush_count !== 32'(m_flushes)) begin
            mismatched++;
            $display("[TB] FAIL random_perf got=%0d/%0d exp=%0d/%0d",
                     stall_cycles, flush_count, m_stalls, m_flushes);
        end
`endif
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        #1;
        advance();
        begin_cycle();
        dx_is_load = 1'b1; dx_rd = 5'd8; fd_rs = 5'd8; fd_uses_rs = 1'b1;
        advance();
        begin_cycle();
        md_start = 1'b1;
        advance();
        for (int i = 0; i < L; i++) begin
            begin_cycle();
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            begin_cycle();
            branch_taken = (i < 2);
            advance();
        end
        #1;
        compared++;
        if (stall_cycles !== 32'd5) begin
            mismatched++;
            $display("[TB] FAIL perf_stall got=%0d exp=5", stall_cycles);
        end
        compared++;
        if (flush_count !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL perf_flush got=%0d exp=2", flush_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_md_latency();
        test_priority();
        test_mem_stall_freeze();
        test_md_abort();
        do_reset();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the five-stage pipeline latches (F/D, D/X, X/M, M/W) and the PC register.
- Generates per-latch enable and flush/bubble controls for four cases: load-use hazards, taken-branch redirects, multicycle mult/div occupancy and external memory stalls.
- Owns the only state machine in the control path: the mult/div occupancy counter.
- Sits beside the datapath. Inputs are decoded fields from the D and X stages; outputs drive the latches' enable and reset-to-NOP inputs.

Parameters:
- MD_LATENCY, 32, number of stall cycles a mult/div instruction holds the X stage (legal range ≥1).
- REG_ADDR_W, 5, register-specifier width.
- CNT_W, 6, width of the mult/div down-counter (must hold MD_LATENCY-1).

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- fd_rs  in  REG_ADDR_W  rs specifier of the instruction in D.
- fd_rt  in  REG_ADDR_W  rt specifier of the instruction in D.
- fd_uses_rs  in  1  D instruction reads rs.
- fd_uses_rt  in  1  D instruction reads rt.
- dx_is_load  in  1  X instruction is a load.
- dx_rd  in  REG_ADDR_W  destination of the X instruction.
- branch_taken  in  1  X resolved a taken branch or jump.
- md_start  in  1  X instruction is mult/div.
- mem_stall  in  1  data/instruction memory not ready.
- pc_en, fd_en, dx_en, xm_en, mw_en  out  1 each  latch/PC load enables.
- fd_flush, dx_flush  out  1 each  latch loads NOP at next edge (when its enable is 1).
- xm_bubble  out  1  X/M loads NOP instead of X results.
- md_busy  out  1  FSM in MD_BUSY.
- md_done  out  1  single-cycle pulse in the final mult/div cycle.

Behaviour:
- Reset (reset=0, async):
  - state=RUN, counter=0.
  - All enables=0; all flush/bubble outputs=0; md_busy=0; md_done=0.
- The FSM has two states, RUN and MD_BUSY. All outputs are combinational from state, counter and inputs; there is zero added latency.
- Load-use hazard, lu:
  - lu = dx_is_load & (dx_rd != 0) & ((fd_uses_rs & fd_rs == dx_rd) | (fd_uses_rt & fd_rt == dx_rd)).
- Priority, highest first:
  1. mem_stall=1 → all enables 0, flushes/bubble 0. FSM state and counter hold. No event is consumed.
  2. MD_BUSY with counter>0 → pc_en=fd_en=dx_en=0; xm_en=1, xm_bubble=1; mw_en=1. Counter decrements by 1.
  3. MD_BUSY with counter=0 → md_done=1, all enables 1, no flush. Next state is RUN. md_start is ignored this cycle; it refers to the departing instruction.
  4. RUN with md_start=1 → same stall pattern as item 2. Load counter with MD_LATENCY-1; next state is MD_BUSY. branch_taken and lu are ignored this cycle.
  5. RUN with branch_taken=1 → all enables 1, fd_flush=1, dx_flush=1. lu is ignored, since the D instruction is squashed anyway.
  6. RUN with lu=1 → pc_en=0, fd_en=0; dx_en=1, dx_flush=1; xm_en=mw_en=1. This is exactly one bubble; the next cycle re-evaluates.
  7. Otherwise → all enables 1, all flush/bubble 0.
- Mult/div timing: md_start first seen in cycle T stalls the front end in cycles T..T+MD_LATENCY-1. md_done pulses in cycle T+MD_LATENCY. For MD_LATENCY=1, md_done pulses at T+1.
- md_busy = (state == MD_BUSY), including the md_done cycle.
- Reset asserted mid-mult/div aborts the operation immediately. No md_done is emitted.
- The counter never underflows; in RUN it is held at 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0], both cleared by reset.
  - stall_cycles increments each cycle with pc_en=0 while reset=1, including mem_stall cycles.
  - flush_count increments each cycle in which priority case 5 fires.
  - Both counters wrap modulo 2^32.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Release reset with no hazards → all enables 1, flushes 0 from the first cycle; assert reset mid-run → every output 0 immediately, asynchronously.
- dx_is_load=1, dx_rd=8, fd_rs=8, fd_uses_rs=1 for one cycle → pc_en=fd_en=0, dx_flush=1 for exactly 1 cycle. Repeat with dx_rd=0 → no stall.
- MD_LATENCY=4, md_start=1 held for 5 cycles → cycles 0-3 xm_bubble=1, front end stalled, md_busy=1 from cycle 1; cycle 4 md_done=1, all enables 1; cycle 5 RUN, no restart.
- branch_taken=1 and lu=1 together → fd_flush=dx_flush=1, pc_en=1, no stall. md_start=1 and branch_taken=1 together → MD stall wins.
- MD_BUSY at counter=2, mem_stall=1 for 3 cycles → all enables 0 and counter frozen; after release, 2 more stall cycles, then md_done.
- With HAZARD_PERF_CNT_EN: 1 load-use stall + 4-cycle mult/div + 2 branches → stall_cycles=5, flush_count=2.
